// File: rtl/bsg_mem_1rw_sync_ctrl.sv
// Single-port sync RAM initiator: valid/ready requests in, valid/yumi read responses out (optional zero-fill via BSG_MEM_1RW_SYNC_CTRL_ZERO_INIT_EN).
// Latency: requests reach the RAM combinationally; read data is returned the cycle after accept (bypass), or later from the buffer.
// Backpressure: req_ready_o drops when buffered plus in-flight reads reach resp_els_p, so a stalled consumer never loses data.
module bsg_mem_1rw_sync_ctrl #(
    parameter int width_p    = 8,
    parameter int els_p      = 16,
    parameter int resp_els_p = 2,
    localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     req_v_i,
    output logic                     req_ready_o,
    input  logic                     req_w_i,
    input  logic [addr_width_lp-1:0] req_addr_i,
    input  logic [width_p-1:0]       req_data_i,
    output logic                     mem_v_o,
    output logic                     mem_w_o,
    output logic [addr_width_lp-1:0] mem_addr_o,
    output logic [width_p-1:0]       mem_data_o,
    input  logic [width_p-1:0]       mem_data_i,
    output logic                     resp_v_o,
    output logic [width_p-1:0]       resp_data_o,
    input  logic                     resp_yumi_i,
    output logic                     init_done_o
);

    localparam int PTR_W = (resp_els_p > 1) ? $clog2(resp_els_p) : 1;
    localparam int OCC_W = $clog2(resp_els_p + 1);
    localparam logic [OCC_W:0]         RESP_ELS  = (OCC_W+1)'(resp_els_p);
    localparam logic [PTR_W-1:0]       PTR_LAST  = PTR_W'(resp_els_p - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_e;

    state_e                     r_state;
    state_e                     w_state_nxt;
    logic                       r_init_done;
    logic                       r_infl;
    logic [OCC_W-1:0]           r_occ;
    logic [PTR_W-1:0]           r_rd_ptr;
    logic [PTR_W-1:0]           r_wr_ptr;
    logic [width_p-1:0]         r_buf [resp_els_p];

    logic                       w_credit_ok;
    logic                       w_req_ready;
    logic                       w_req_fire;
    logic                       w_buf_empty;
    logic                       w_resp_v;
    logic                       w_enq;
    logic                       w_deq;
    logic                       w_mem_v;
    logic                       w_mem_w;
    logic [addr_width_lp-1:0]   w_mem_addr;
    logic [width_p-1:0]         w_mem_data;

`ifdef BSG_MEM_1RW_SYNC_CTRL_ZERO_INIT_EN
    localparam logic [addr_width_lp-1:0] ADDR_LAST = addr_width_lp'(els_p - 1);
    localparam state_e ST_RESET = ST_INIT;

    logic [addr_width_lp-1:0]   r_init_addr;
    logic [addr_width_lp-1:0]   w_init_addr_nxt;
`else
    localparam state_e ST_RESET = ST_IDLE;
`endif

    // Credits cover both buffered entries and the read whose data arrives this cycle.
    assign w_credit_ok = ({1'b0, r_occ} + (OCC_W+1)'(r_infl)) < RESP_ELS;
    assign w_req_ready = reset_n_i & (r_state == ST_IDLE) & w_credit_ok;
    assign w_req_fire  = req_v_i & w_req_ready;

    assign w_buf_empty = (r_occ == '0);
    assign w_resp_v    = ~w_buf_empty | r_infl;
    assign w_deq       = resp_yumi_i & ~w_buf_empty;
    assign w_enq       = r_infl & ~(w_buf_empty & resp_yumi_i);

    always_comb begin
        w_state_nxt = r_state;
        w_mem_v     = 1'b0;
        w_mem_w     = 1'b0;
        w_mem_addr  = '0;
        w_mem_data  = '0;
`ifdef BSG_MEM_1RW_SYNC_CTRL_ZERO_INIT_EN
        w_init_addr_nxt = r_init_addr;
`endif
        case (r_state)
`ifdef BSG_MEM_1RW_SYNC_CTRL_ZERO_INIT_EN
            ST_INIT: begin
                w_mem_v    = 1'b1;
                w_mem_w    = 1'b1;
                w_mem_addr = r_init_addr;
                if (r_init_addr == ADDR_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_init_addr_nxt = r_init_addr + 1'b1;
                end
            end
`endif
            ST_IDLE: begin
                w_mem_v    = w_req_fire;
                w_mem_w    = req_w_i;
                w_mem_addr = req_addr_i;
                w_mem_data = req_data_i;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state     <= ST_RESET;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_init_done <= (w_state_nxt == ST_IDLE);
        end
    end

`ifdef BSG_MEM_1RW_SYNC_CTRL_ZERO_INIT_EN
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_init_addr <= '0;
        end else begin
            r_init_addr <= w_init_addr_nxt;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_infl   <= 1'b0;
            r_occ    <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_infl <= w_req_fire & ~req_w_i;
            case ({w_enq, w_deq})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
            if (w_enq) begin
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_deq) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
        end
    end

    // Payload storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_buf[r_wr_ptr] <= mem_data_i;
        end
    end

    assign req_ready_o = w_req_ready;
    assign mem_v_o     = reset_n_i & w_mem_v;
    assign mem_w_o     = reset_n_i & w_mem_w;
    assign mem_addr_o  = reset_n_i ? w_mem_addr : '0;
    assign mem_data_o  = reset_n_i ? w_mem_data : '0;
    assign resp_v_o    = w_resp_v;
    assign resp_data_o = !reset_n_i ? '0 : (w_buf_empty ? mem_data_i : r_buf[r_rd_ptr]);
    assign init_done_o = r_init_done;

`ifndef SYNTHESIS
    yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        resp_yumi_i |-> w_resp_v);
`endif

endmodule

// File: tb/tb_bsg_mem_1rw_sync_ctrl.sv
// Directed bench for bsg_mem_1rw_sync_ctrl with a 1-cycle RAM model and an in-order response scoreboard.
module tb_bsg_mem_1rw_sync_ctrl;
    localparam int W = 8;
    localparam int E = 5;
    localparam int R = 2;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset_n_i;
    logic          req_v_i, req_ready_o, req_w_i;
    logic [AW-1:0] req_addr_i;
    logic [W-1:0]  req_data_i;
    logic          mem_v_o, mem_w_o;
    logic [AW-1:0] mem_addr_o;
    logic [W-1:0]  mem_data_o, mem_data_i;
    logic          resp_v_o;
    logic [W-1:0]  resp_data_o;
    logic          resp_yumi_i;
    logic          init_done_o;

    logic [W-1:0]  ram [0:7];
    logic [W-1:0]  sh  [0:7];
    logic [W-1:0]  q [$];
    logic          auto_yumi;
    int            n_chk = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    bsg_mem_1rw_sync_ctrl #(.width_p(W), .els_p(E), .resp_els_p(R)) dut (
        .clk_i(clk), .reset_n_i(reset_n_i),
        .req_v_i(req_v_i), .req_ready_o(req_ready_o), .req_w_i(req_w_i),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
        .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .resp_yumi_i(resp_yumi_i),
        .init_done_o(init_done_o)
    );

    always @(posedge clk) begin
        if (mem_v_o) begin
            if (mem_w_o) ram[mem_addr_o] <= mem_data_o;
            else         mem_data_i <= ram[mem_addr_o];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic half();
        @(negedge clk);
        if (auto_yumi) resp_yumi_i = resp_v_o;
    endtask

    // Scoreboard bookkeeping for the edge about to happen, then step past it.
    task automatic fin();
        logic [W-1:0] e;
        if (resp_v_o && resp_yumi_i) begin
            if (q.size() == 0) begin
                chk("resp_unexpected", 32'(resp_v_o), 32'd0);
            end else begin
                e = q.pop_front();
                chk("resp_data", 32'(resp_data_o), 32'(e));
            end
        end
        if (req_v_i && req_ready_o) begin
            if (req_w_i) sh[req_addr_i] = req_data_i;
            else         q.push_back(sh[req_addr_i]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        half();
        fin();
    endtask

    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [W-1:0] d);
        logic acc;
        acc = 1'b0;
        req_v_i = 1'b1; req_w_i = w; req_addr_i = a; req_data_i = d;
        for (int i = 0; i < 20; i++) begin
            half();
            acc = req_ready_o;
            fin();
            if (acc) break;
        end
        req_v_i = 1'b0;
        chk("issue_accept", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        auto_yumi = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (q.size() == 0) break;
            tick();
        end
        auto_yumi = 1'b0;
        resp_yumi_i = 1'b0;
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    task automatic wait_init();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            half();
            done = init_done_o;
            fin();
            if (done) break;
        end
        chk("init_done_wait", 32'(done), 32'd1);
    endtask

    initial begin
        reset_n_i = 1'b0; req_v_i = 1'b0; req_w_i = 1'b0; req_addr_i = '0;
        req_data_i = '0; resp_yumi_i = 1'b0; auto_yumi = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ram[i] = 8'hEE;
            sh[i]  = 8'hEE;
        end
        repeat (2) @(posedge clk);
        #1;
        req_v_i = 1'b1; req_w_i = 1'b1; req_addr_i = 3'd2; req_data_i = 8'h77;
        #1;
        chk("rst_ready", 32'(req_ready_o), 32'd0);
        chk("rst_mem_v", 32'(mem_v_o), 32'd0);
        chk("rst_mem_w", 32'(mem_w_o), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr_o), 32'd0);
        chk("rst_resp_v", 32'(resp_v_o), 32'd0);
        chk("rst_init_done", 32'(init_done_o), 32'd0);
        req_v_i = 1'b0; req_w_i = 1'b0; req_addr_i = '0; req_data_i = '0;
        @(posedge clk);
        #1;
        reset_n_i = 1'b1;

`ifdef BSG_MEM_1RW_SYNC_CTRL_ZERO_INIT_EN
        for (int i = 0; i < E; i++) begin
            half();
            chk("init_mem_v", 32'(mem_v_o), 32'd1);
            chk("init_mem_w", 32'(mem_w_o), 32'd1);
            chk("init_mem_addr", 32'(mem_addr_o), 32'(i));
            chk("init_mem_data", 32'(mem_data_o), 32'd0);
            chk("init_ready", 32'(req_ready_o), 32'd0);
            chk("init_done_low", 32'(init_done_o), 32'd0);
            fin();
        end
        for (int i = 0; i < E; i++) sh[i] = '0;
`else
        half();
        chk("init_done_low", 32'(init_done_o), 32'd0);
        fin();
`endif
        half();
        chk("init_done_high", 32'(init_done_o), 32'd1);
        chk("idle_ready", 32'(req_ready_o), 32'd1);
        fin();

`ifdef BSG_MEM_1RW_SYNC_CTRL_ZERO_INIT_EN
        issue(1'b0, 3'd4, '0);
        drain();
`endif

        // Write 0xA5 to address 3 and read it back.
        req_v_i = 1'b1; req_w_i = 1'b1; req_addr_i = 3'd3; req_data_i = 8'hA5;
        half();
        chk("wr_mem_v", 32'(mem_v_o), 32'd1);
        chk("wr_mem_w", 32'(mem_w_o), 32'd1);
        chk("wr_mem_addr", 32'(mem_addr_o), 32'd3);
        chk("wr_mem_data", 32'(mem_data_o), 32'hA5);
        fin();
        req_w_i = 1'b0;
        half();
        chk("rd_ready", 32'(req_ready_o), 32'd1);
        chk("rd_resp_v_same_cycle", 32'(resp_v_o), 32'd0);
        fin();
        req_v_i = 1'b0;
        half();
        chk("rd_resp_v_next", 32'(resp_v_o), 32'd1);
        chk("rd_resp_data_next", 32'(resp_data_o), 32'hA5);
        resp_yumi_i = 1'b1;
        fin();
        resp_yumi_i = 1'b0;
        chk("rd_q_empty", 32'(q.size()), 32'd0);

        for (int a = 0; a < E; a++) issue(1'b1, AW'(a), 8'(16 + 17 * a));

        // Credit limit with a stalled consumer.
        req_v_i = 1'b1; req_w_i = 1'b0; req_addr_i = 3'd0;
        half(); chk("cr_ready0", 32'(req_ready_o), 32'd1); fin();
        req_addr_i = 3'd1;
        half(); chk("cr_ready1", 32'(req_ready_o), 32'd1); fin();
        req_addr_i = 3'd2;
        half();
        chk("cr_ready2_blocked", 32'(req_ready_o), 32'd0);
        chk("cr_resp_v", 32'(resp_v_o), 32'd1);
        fin();
        half();
        chk("cr_ready3_blocked", 32'(req_ready_o), 32'd0);
        resp_yumi_i = 1'b1;
        fin();
        resp_yumi_i = 1'b0;
        half();
        chk("cr_ready_rise", 32'(req_ready_o), 32'd1);
        fin();
        req_v_i = 1'b0;
        chk("cr_outstanding", 32'(q.size()), 32'd2);
        drain();

        // Streaming reads with a consumer that always takes.
        auto_yumi = 1'b1;
        for (int i = 0; i < 16; i++) begin
            req_v_i = 1'b1; req_w_i = 1'b0; req_addr_i = AW'(i % E);
            half();
            chk("stream_ready", 32'(req_ready_o), 32'd1);
            fin();
        end
        req_v_i = 1'b0;
        drain();

        // Reset with two buffered reads discards them.
        issue(1'b0, 3'd0, '0);
        issue(1'b0, 3'd1, '0);
        tick();
        half();
        chk("pre_rst_resp_v", 32'(resp_v_o), 32'd1);
        reset_n_i = 1'b0;
        #1;
        chk("mid_rst_resp_v", 32'(resp_v_o), 32'd0);
        q.delete();
        @(posedge clk);
        #1;
        reset_n_i = 1'b1;
`ifdef BSG_MEM_1RW_SYNC_CTRL_ZERO_INIT_EN
        for (int i = 0; i < E; i++) sh[i] = '0;
`endif
        wait_init();
        for (int i = 0; i < 6; i++) begin
            half();
            chk("no_stale_resp", 32'(resp_v_o), 32'd0);
            fin();
        end
        issue(1'b0, 3'd4, '0);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
